// File: rtl/text_pixel_streamer_if.sv
// text_pixel_streamer_if: font ROM lookup port and RGB pixel stream between the streamer and the OLED framer.
interface text_pixel_streamer_if #(
   parameter int COLOR_W = 16
);
   logic               font_req;
   logic [7:0]         font_char;
   logic [2:0]         font_row;
   logic [7:0]         font_bits;
   logic               pix_valid;
   logic               pix_ready;
   logic [COLOR_W-1:0] pix_data;
   logic               pix_last;
   modport master (
      output font_req, font_char, font_row, pix_valid, pix_data, pix_last,
      input  font_bits, pix_ready
   );
   modport slave (
      input  font_req, font_char, font_row, pix_valid, pix_data, pix_last,
      output font_bits, pix_ready
   );
endinterface

// File: rtl/text_pixel_streamer.sv
// text_pixel_streamer: renders a latched NUM_CHARS-character string through an 8x8 font ROM
// into a row-major RGB565 pixel stream with valid/ready flow control.
module text_pixel_streamer #(
   parameter int NUM_CHARS = 3,
   parameter int COLOR_W   = 16,
   parameter int FONT_LAT  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [8*NUM_CHARS-1:0] str_ascii,
   input  logic [COLOR_W-1:0]     fg_color,
   input  logic [COLOR_W-1:0]     bg_color,
   text_pixel_streamer_if.master  bus,
   output logic                   busy,
   output logic                   done
);
   localparam int CW = NUM_CHARS > 1 ? $clog2(NUM_CHARS) : 1;
   localparam logic [CW-1:0] C_LAST   = CW'(NUM_CHARS - 1);
   localparam logic [1:0]    LAT_LAST = 2'(FONT_LAT - 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   logic [2:0]             state_q, state_d;
   logic [8*NUM_CHARS-1:0] str_q, str_d;
   logic [COLOR_W-1:0]     fg_q, fg_d, bg_q, bg_d;
   logic [2:0]             col_q, col_d, r_q, r_d;
   logic [CW-1:0]          c_q, c_d;
   logic [1:0]             wait_q, wait_d;
   logic [7:0]             glyph_q, glyph_d;
   logic                   fetch, shift, accept, last_px;
   assign fetch   = state_q == S_FETCH;
   assign shift   = state_q == S_SHIFT;
   assign accept  = shift && bus.pix_ready;
   assign last_px = shift && r_q == 3'd7 && c_q == C_LAST && col_q == 3'd7;
   // Outputs decode from state so an abort by rst zeroes them on the very next cycle.
   assign bus.font_req  = fetch;
   assign bus.font_char = fetch ? str_q[8*c_q +: 8] : 8'd0;
   assign bus.font_row  = fetch ? r_q : 3'd0;
   assign bus.pix_valid = shift;
   assign bus.pix_data  = !shift ? '0 : glyph_q[col_q] ? fg_q : bg_q;
   assign bus.pix_last  = last_px;
   assign busy = state_q != S_IDLE;
   assign done = state_q == S_DONE;
   always_comb begin
      state_d = state_q;
      str_d   = str_q;
      fg_d    = fg_q;
      bg_d    = bg_q;
      col_d   = col_q;
      c_d     = c_q;
      r_d     = r_q;
      wait_d  = wait_q;
      glyph_d = glyph_q;
      case (state_q)
         S_IDLE: if (start) begin
            str_d   = str_ascii;
            fg_d    = fg_color;
            bg_d    = bg_color;
            col_d   = 3'd0;
            c_d     = '0;
            r_d     = 3'd0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            wait_d  = 2'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wait_d  = wait_q + 2'd1;
            glyph_d = wait_q == LAT_LAST ? bus.font_bits : glyph_q;
            state_d = wait_q == LAT_LAST ? S_SHIFT : S_WAIT;
         end
         S_SHIFT: if (accept) begin
            col_d = col_q + 3'd1;
            if (col_q == 3'd7) begin
               c_d     = c_q == C_LAST ? '0 : c_q + 1'b1;
               r_d     = c_q == C_LAST ? r_q + 3'd1 : r_q;
               state_d = last_px ? S_DONE : S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         str_q   <= '0;
         fg_q    <= '0;
         bg_q    <= '0;
         col_q   <= 3'd0;
         c_q     <= '0;
         r_q     <= 3'd0;
         wait_q  <= 2'd0;
         glyph_q <= 8'd0;
      end else begin
         state_q <= state_d;
         str_q   <= str_d;
         fg_q    <= fg_d;
         bg_q    <= bg_d;
         col_q   <= col_d;
         c_q     <= c_d;
         r_q     <= r_d;
         wait_q  <= wait_d;
         glyph_q <= glyph_d;
      end
   end
endmodule

// File: tb/tb_text_pixel_streamer.sv
// tb_text_pixel_streamer: two streamers (font latency 1 and 3) driven with identical stimulus,
// each stream compared against a raster-order model of the string rendering.
module tb_text_pixel_streamer;
   logic        clk = 1'b0;
   logic        rst, start, ready;
   logic [23:0] str_ascii;
   logic [15:0] fg, bg;
   logic        busy0, done0, busy1, done1;
   logic [7:0]  rom0_q;
   logic [7:0]  rom1_q [3];
   int          checks, errors;
   logic [16:0] exp_pix [192];
   logic [10:0] exp_req [24];
   logic [16:0] got_pix [2][256];
   logic [10:0] got_req [2][32];
   int          got_n [2], req_n [2], busy_n [2], done_n [2];
   logic        stall_p [2], last_acc [2], held_l [2];
   logic [15:0] held_d [2];
   logic        rst_p;
   logic [15:0] go_exp [16] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                                16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
   always #5 clk = ~clk;
   text_pixel_streamer_if #(.COLOR_W(16)) i0 ();
   text_pixel_streamer_if #(.COLOR_W(16)) i1 ();
   text_pixel_streamer #(.NUM_CHARS(3), .COLOR_W(16), .FONT_LAT(1)) dut0 (
      .clk(clk), .rst(rst), .start(start), .str_ascii(str_ascii), .fg_color(fg), .bg_color(bg),
      .bus(i0.master), .busy(busy0), .done(done0));
   text_pixel_streamer #(.NUM_CHARS(3), .COLOR_W(16), .FONT_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .start(start), .str_ascii(str_ascii), .fg_color(fg), .bg_color(bg),
      .bus(i1.master), .busy(busy1), .done(done1));
   function automatic logic [7:0] rom(input logic [7:0] ch, input logic [2:0] row);
      if (row == 3'd0 && ch == "G") return 8'h3C;
      if (row == 3'd0 && ch == "O") return 8'h1C;
      return (ch * 8'd29) ^ (8'd1 << row) ^ {row, 5'd3};
   endfunction
   // Font ROM models: junk outside the read window exposes a mistimed capture.
   always @(posedge clk) begin
      rom0_q    <= i0.font_req ? rom(i0.font_char, i0.font_row) : 8'h5A;
      rom1_q[0] <= i1.font_req ? rom(i1.font_char, i1.font_row) : 8'h5A;
      rom1_q[1] <= rom1_q[0];
      rom1_q[2] <= rom1_q[1];
   end
   assign i0.font_bits = rom0_q;
   assign i1.font_bits = rom1_q[2];
   assign i0.pix_ready = ready;
   assign i1.pix_ready = ready;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic mon(input int d, input logic valid, input logic rdy, input logic last, input logic [15:0] data,
                      input logic req, input logic [7:0] ch, input logic [2:0] row, input logic bsy, input logic dn);
      if (stall_p[d] && !rst_p) begin
         chk("stall_valid", valid, 1);
         chk("stall_data", data, held_d[d]);
         chk("stall_last", last, held_l[d]);
      end
      chk("done_timing", dn, last_acc[d] && !rst_p);
      if (valid && rdy) begin
         if (got_n[d] < 256) got_pix[d][got_n[d]] = {last, data};
         got_n[d]++;
      end
      if (req) begin
         if (req_n[d] < 32) got_req[d][req_n[d]] = {ch, row};
         req_n[d]++;
      end
      if (bsy) busy_n[d]++;
      if (dn) done_n[d]++;
      last_acc[d] = valid && rdy && last;
      stall_p[d]  = valid && !rdy;
      held_d[d]   = data;
      held_l[d]   = last;
   endtask
   always @(negedge clk) begin
      mon(0, i0.pix_valid, i0.pix_ready, i0.pix_last, i0.pix_data, i0.font_req, i0.font_char, i0.font_row, busy0, done0);
      mon(1, i1.pix_valid, i1.pix_ready, i1.pix_last, i1.pix_data, i1.font_req, i1.font_char, i1.font_row, busy1, done1);
      rst_p = rst;
   end
   task automatic build(input logic [23:0] s, input logic [15:0] f, input logic [15:0] b);
      logic [7:0] g, ch;
      int k;
      k = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 3; c++) begin
            ch = s[8*c +: 8];
            g = rom(ch, 3'(r));
            exp_req[r*3+c] = {ch, 3'(r)};
            for (int x = 0; x < 8; x++) begin
               exp_pix[k] = {k == 191, g[x] ? f : b};
               k++;
            end
         end
   endtask
   task automatic begin_frame(input logic [23:0] s, input logic [15:0] f, input logic [15:0] b);
      build(s, f, b);
      for (int d = 0; d < 2; d++) begin
         got_n[d] = 0; req_n[d] = 0; busy_n[d] = 0; done_n[d] = 0;
      end
      str_ascii = s; fg = f; bg = b; start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   task automatic zero_check(input string tag);
      chk({tag, "_dut0"}, {i0.font_req, i0.font_char, i0.font_row, i0.pix_valid, i0.pix_data, i0.pix_last, busy0, done0}, 0);
      chk({tag, "_dut1"}, {i1.font_req, i1.font_char, i1.font_row, i1.pix_valid, i1.pix_data, i1.pix_last, busy1, done1}, 0);
   endtask
   // mode 1 re-pulses start with another string once 50 pixels have gone out.
   task automatic run_frame(input logic [23:0] s, input logic [15:0] f, input logic [15:0] b, input int mode, input bit rnd);
      bit poked;
      poked = 0;
      begin_frame(s, f, b);
      for (int cyc = 0; cyc < 3000 && (done_n[0] == 0 || done_n[1] == 0); cyc++) begin
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start = 1'b0;
         if (mode == 1 && !poked && got_n[0] >= 50) begin
            poked = 1; start = 1'b1; str_ascii = 24'h414243; fg = 16'h1234; bg = 16'h4321;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("pix_count", got_n[d], 192);
         for (int i = 0; i < 192 && i < got_n[d]; i++) chk($sformatf("pix%0d_d%0d", i, d), got_pix[d][i], exp_pix[i]);
         chk("req_count", req_n[d], 24);
         for (int i = 0; i < 24 && i < req_n[d]; i++) chk($sformatf("req%0d_d%0d", i, d), got_req[d][i], exp_req[i]);
         chk("done_count", done_n[d], 1);
         if (!rnd) chk("busy_cycles", busy_n[d], d == 0 ? 241 : 289);
      end
   endtask
   task automatic run_abort(input logic [23:0] s, input logic [15:0] f, input logic [15:0] b);
      begin_frame(s, f, b);
      for (int cyc = 0; cyc < 3000 && got_n[0] < 100; cyc++) begin
         ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      chk("abort_reached", got_n[0], 100);
      rst = 1'b1;
      @(posedge clk); #1;
      zero_check("abort_zero");
      rst = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      chk("abort_done0", done_n[0], 0);
      chk("abort_done1", done_n[1], 0);
      chk("abort_idle", {busy0, busy1}, 0);
   endtask
   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; start = 1'b0; ready = 1'b0; str_ascii = '0; fg = '0; bg = '0;
      repeat (3) @(posedge clk);
      #1;
      zero_check("reset");
      rst = 1'b0;
      run_frame({" ", "O", "G"}, 16'hFFFF, 16'h0000, 0, 0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("go_px%0d_d0", i), got_pix[0][i][15:0], go_exp[i]);
         chk($sformatf("go_px%0d_d1", i), got_pix[1][i][15:0], go_exp[i]);
      end
      run_frame({"S", "R", "E"}, 16'hF800, 16'h07E0, 0, 0);
      run_frame({"S", "R", "E"}, 16'hF800, 16'h07E0, 0, 1);
      run_frame({"S", "R", "E"}, 16'hF800, 16'h07E0, 1, 0);
      run_abort({"S", "R", "E"}, 16'hF800, 16'h07E0);
      run_frame({"S", "R", "E"}, 16'hF800, 16'h07E0, 0, 0);
      for (int n = 0; n < 3; n++)
         run_frame({8'($urandom_range(32, 126)), 8'($urandom_range(32, 126)), 8'($urandom_range(32, 126))},
                   16'($urandom), 16'($urandom), 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
